// File: rtl/pulse_to_level_if.sv
// Purpose: request/level bundle between a pulse_to_level block and its user.
// Ports (signals):
//   pulse        request, one request per high cycle (master -> slave)
//   clr_overflow clears the sticky overflow flag     (master -> slave)
//   level        generated level waveform             (slave -> master)
//   busy         block is not idle                    (slave -> master)
//   pending      queued request count                 (slave -> master)
//   overflow     sticky: a request was dropped        (slave -> master)
interface pulse_to_level_if #(
  parameter int unsigned PENDING_MAX = 2
);
  localparam int unsigned PW = (PENDING_MAX > 0) ? $clog2(PENDING_MAX + 1) : 1;

  logic          pulse;
  logic          clr_overflow;
  logic          level;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output pulse, clr_overflow,
    input  level, busy, pending, overflow
  );

  modport slave (
    input  pulse, clr_overflow,
    output level, busy, pending, overflow
  );
endinterface

// File: rtl/pulse_to_level.sv
// Purpose: turns single-cycle request pulses into stretched level pulses
// (stretch-high / stretch-low) or level toggles, queueing requests that
// arrive while an output is in progress.
// Ports:
//   clk    system clock, posedge
//   rst_n  synchronous active-low reset
//   p2l    slave side of pulse_to_level_if (pulse, clr_overflow in;
//          level, busy, pending, overflow out; all outputs registered)
module pulse_to_level #(
  parameter logic [1:0]  MODE        = 2'b01,
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 1,
  parameter int unsigned PENDING_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pulse_to_level_if.slave  p2l
);
  localparam int unsigned PW   = (PENDING_MAX > 0) ? $clog2(PENDING_MAX + 1) : 1;
  localparam int unsigned HMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned CW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam bit   ENABLED  = (MODE != 2'b00);
  localparam bit   TOGGLE   = (MODE == 2'b11);
  localparam logic ACT_LVL  = (MODE == 2'b01);
  localparam logic IDLE_LVL = (MODE == 2'b10);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          busy_q;
  logic          req_avail;
  logic          take;
  logic          h_last;
  logic          l_last;

  assign req_avail = p2l.pulse | (pend_q != '0);
  assign h_last    = (cnt_q == CW'(HIGH_CYCLES - 1));
  assign l_last    = (cnt_q == CW'(LOW_CYCLES - 1));

  // Next-state: sequencing, request consumption and queue bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q & ~p2l.clr_overflow;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        if (p2l.pulse) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          level_d = TOGGLE ? ~level_q : ACT_LVL;
          take    = 1'b1;
        end
      end
      ACTIVE: begin
        if (!h_last) begin
          cnt_d = cnt_q + CW'(1);
        end else if (TOGGLE) begin
          cnt_d = '0;
          if (req_avail) begin
            level_d = ~level_q;
            take    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GAP;
          cnt_d   = '0;
          level_d = IDLE_LVL;
        end
      end
      GAP: begin
        if (!l_last) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (req_avail) begin
            state_d = ACTIVE;
            level_d = ACT_LVL;
            take    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A pulse in a consuming cycle is used directly; otherwise a consume
    // drains the queue. An unconsumed pulse queues or, when full, is dropped.
    if (take && !p2l.pulse) begin
      pend_d = pend_q - PW'(1);
    end else if (p2l.pulse && !take) begin
      if (pend_q != PW'(PENDING_MAX)) begin
        pend_d = pend_q + PW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State and registered outputs; disabled modes stay in the reset state.
  always_ff @(posedge clk) begin
    if (!rst_n || !ENABLED) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      level_q <= ENABLED ? IDLE_LVL : 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign p2l.level    = level_q;
  assign p2l.busy     = busy_q;
  assign p2l.pending  = pend_q;
  assign p2l.overflow = ovf_q;
endmodule
